memory_access_unit: RTL and testbench

Initiator-side controller for the CPU's 256-byte synchronous `memory` block. It accepts load, store and block-copy requests from the CPU core over a valid/ready handshake. It sequences `MemRead`/`MemWrite`/`address`/`data_in` toward the memory, accounting for that memory's one-cycle registered read. It returns one response per request. It sits between the CPU datapath and `memory`, and is the only driver of the memory's control inputs.

---
 rtl/memory_access_unit.sv | 181 ++++++++++++++++++
 tb/tb_memory_access_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_unit.sv
// memory_access_unit: initiator-side sequencer for the 256-byte synchronous
// memory. Serves LOAD, STORE and forward block COPY requests over a
// valid/ready handshake and returns one registered response per request.
// Every memory-side and response output comes straight from a flop, so the
// next value of each output is derived from the next state.
module memory_access_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_dst,
    input  logic [7:0]        req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE, RD, RD_WAIT, WR, CP_RD, CP_WAIT, CP_WR, RESP
    } state_t;

    state_t              state_q, state_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic [ADDR_W-1:0]   src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0]   dst_ptr_q, dst_ptr_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                accept;

    // Ready is forced low while reset is held, even before the edge lands.
    assign req_ready  = (state_q == IDLE) & ~rst;
    assign accept     = req_valid & req_ready;
    assign busy       = (state_q != IDLE);
    assign MemRead    = mem_read_q;
    assign MemWrite   = mem_write_q;
    assign address    = address_q;
    assign data_out   = data_out_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    // State register with asynchronous reset back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state sequencing; a COPY of zero bytes and the reserved op skip
    // the memory entirely and answer on the next cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (req_op)
                        OP_LOAD:  state_d = RD;
                        OP_STORE: state_d = WR;
                        OP_COPY:  state_d = (req_len == 8'd0) ? RESP : CP_RD;
                        default:  state_d = RESP;
                    endcase
                end
            end
            RD:      state_d = RD_WAIT;
            RD_WAIT: state_d = RESP;
            WR:      state_d = RESP;
            CP_RD:   state_d = CP_WAIT;
            CP_WAIT: state_d = CP_WR;
            CP_WR:   state_d = (cnt_q == 8'd0) ? RESP : CP_RD;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; strobes follow the state being
    // entered so they appear registered in that state's cycle.
    always_comb begin
        mem_read_d   = (state_d == RD) || (state_d == CP_RD);
        mem_write_d  = (state_d == WR) || (state_d == CP_WR);
        resp_valid_d = (state_d == RESP);
        address_d    = address_q;
        data_out_d   = data_out_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        hold_d       = hold_q;
        src_ptr_d    = src_ptr_q;
        dst_ptr_d    = dst_ptr_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    src_ptr_d = req_addr + ADDR_W'(1);
                    dst_ptr_d = req_dst;
                    cnt_d     = req_len;
                    if (state_d != RESP) address_d = req_addr;
                    if (req_op == OP_STORE) data_out_d = req_wdata;
                    if (state_d == RESP) begin
                        resp_err_d   = (req_op == OP_RSVD);
                        resp_rdata_d = '0;
                    end
                end
            end
            RD_WAIT: begin
                resp_rdata_d = mem_rdata;
                resp_err_d   = 1'b0;
            end
            WR: resp_err_d = 1'b0;
            CP_WAIT: begin
                // Byte is captured once and written in the following cycle;
                // the counter tracks bytes still to go after this one.
                hold_d     = mem_rdata;
                data_out_d = mem_rdata;
                address_d  = dst_ptr_q;
                dst_ptr_d  = dst_ptr_q + ADDR_W'(1);
                cnt_d      = cnt_q - 8'd1;
            end
            CP_WR: begin
                if (cnt_q == 8'd0) begin
                    resp_rdata_d = hold_q;
                    resp_err_d   = 1'b0;
                end else begin
                    address_d = src_ptr_q;
                    src_ptr_d = src_ptr_q + ADDR_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers; reset drops the strobes immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            address_q    <= '0;
            data_out_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            hold_q       <= '0;
            src_ptr_q    <= '0;
            dst_ptr_q    <= '0;
            cnt_q        <= '0;
        end else begin
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            address_q    <= address_d;
            data_out_q   <= data_out_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            hold_q       <= hold_d;
            src_ptr_q    <= src_ptr_d;
            dst_ptr_q    <= dst_ptr_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// Testbench for memory_access_unit: attaches a behavioural 256-byte memory
// with registered read and compares every transaction against a byte-level
// reference model of LOAD/STORE/COPY semantics and latencies.
module tb_memory_access_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_addr;
    logic [7:0] req_dst;
    logic [7:0] req_len;
    logic [7:0] req_wdata;
    logic       resp_valid;
    logic [7:0] resp_rdata;
    logic       resp_err;
    logic       busy;
    logic       MemRead;
    logic       MemWrite;
    logic [7:0] address;
    logic [7:0] data_out;
    logic [7:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem     [0:255];
    logic [7:0] ref_mem [0:255];
    logic [7:0] exp_ra [$];
    logic [7:0] exp_wa [$];
    logic [7:0] exp_wd [$];

    always #5 clk = ~clk;

    memory_access_unit #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_dst(req_dst), .req_len(req_len),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy), .MemRead(MemRead), .MemWrite(MemWrite),
        .address(address), .data_out(data_out), .mem_rdata(mem_rdata)
    );

    // Behavioural synchronous memory: registered read, synchronous write.
    always @(posedge clk) begin
        if (MemWrite) mem[address] <= data_out;
        if (MemRead)  mem_rdata    <= mem[address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mem_cmp(input string tag);
        int diff = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diff++;
        chk({tag, ".mem_diff"}, diff, 0);
    endtask

    // Reference semantics: updates ref_mem and lists the expected accesses.
    task automatic model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] len, input logic [7:0] wd,
                         output int lat, output logic [7:0] rdata, output logic err);
        exp_ra.delete(); exp_wa.delete(); exp_wd.delete();
        lat = 1; rdata = 8'h00; err = 1'b0;
        case (op)
            2'b00: begin lat = 3; rdata = ref_mem[a]; exp_ra.push_back(a); end
            2'b01: begin
                lat = 2; ref_mem[a] = wd;
                exp_wa.push_back(a); exp_wd.push_back(wd);
            end
            2'b10: begin
                lat = 3 * int'(len) + 1;
                for (int i = 0; i < int'(len); i++) begin
                    logic [7:0] s, t, b;
                    s = a + 8'(i);
                    t = d + 8'(i);
                    b = ref_mem[s];
                    ref_mem[t] = b;
                    rdata = b;
                    exp_ra.push_back(s); exp_wa.push_back(t); exp_wd.push_back(b);
                end
            end
            default: begin lat = 1; err = 1'b1; end
        endcase
    endtask

    task automatic do_req(input string tag, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] d, input logic [7:0] len, input logic [7:0] wd);
        int lat, got_lat, coll, badr, badw, w;
        logic [7:0] er, gr, ea, ed;
        logic ee, ge, busy1;
        got_lat = -1; coll = 0; badr = 0; badw = 0; w = 0;
        gr = 8'h00; ge = 1'b0; busy1 = 1'b0;
        model(op, a, d, len, wd, lat, er, ee);
        while (!req_ready && w < 100) begin @(negedge clk); w++; end
        chk({tag, ".ready"}, req_ready, 1);
        req_valid = 1'b1; req_op = op; req_addr = a; req_dst = d; req_len = len; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op = 2'($urandom); req_addr = 8'($urandom); req_dst = 8'($urandom);
        req_len = 8'($urandom); req_wdata = 8'($urandom);
        for (int c = 1; c <= 800; c++) begin
            @(negedge clk);
            if (c == 1) busy1 = busy;
            if (MemRead && MemWrite) coll++;
            if (MemRead) begin
                if (exp_ra.size() == 0) badr++;
                else begin ea = exp_ra.pop_front(); if (ea !== address) badr++; end
            end
            if (MemWrite) begin
                if (exp_wa.size() == 0) badw++;
                else begin
                    ea = exp_wa.pop_front(); ed = exp_wd.pop_front();
                    if (ea !== address || ed !== data_out) badw++;
                end
            end
            if (resp_valid) begin got_lat = c; gr = resp_rdata; ge = resp_err; break; end
        end
        badr += exp_ra.size();
        badw += exp_wa.size();
        chk({tag, ".latency"}, got_lat, lat);
        chk({tag, ".err"}, ge, ee);
        if (op == 2'b00 || op == 2'b10) chk({tag, ".rdata"}, gr, er);
        chk({tag, ".rd_seq"}, badr, 0);
        chk({tag, ".wr_seq"}, badw, 0);
        chk({tag, ".collide"}, coll, 0);
        chk({tag, ".busy_c1"}, busy1, 1);
        @(negedge clk);
        chk({tag, ".resp_1cyc"}, resp_valid, 0);
        chk({tag, ".ready_after"}, req_ready, 1);
        mem_cmp(tag);
    endtask

    initial begin
        int wr_cnt, rv_cnt, w;
        rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = 8'h00;
        req_dst = 8'h00; req_len = 8'h00; req_wdata = 8'h00;
        #12;
        chk("rst.ready", req_ready, 0);
        chk("rst.busy", busy, 0);
        chk("rst.strobes", {MemRead, MemWrite, resp_valid, resp_err}, 4'b0000);
        chk("rst.addr_data", {address, data_out, resp_rdata}, 24'h000000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel.ready", req_ready, 1);
        chk("rel.busy", busy, 0);

        // Fill memory through the unit so both memories start identical.
        for (int i = 0; i < 256; i++) do_req("preload", 2'b01, 8'(i), 8'h00, 8'h00, 8'($urandom));

        do_req("store_a5", 2'b01, 8'h10, 8'h00, 8'h00, 8'hA5);
        do_req("load_10",  2'b00, 8'h10, 8'h00, 8'h00, 8'h00);

        do_req("st_fe", 2'b01, 8'hFE, 8'h00, 8'h00, 8'h11);
        do_req("st_ff", 2'b01, 8'hFF, 8'h00, 8'h00, 8'h22);
        do_req("st_00", 2'b01, 8'h00, 8'h00, 8'h00, 8'h33);
        do_req("st_01", 2'b01, 8'h01, 8'h00, 8'h00, 8'h44);
        do_req("copy_wrap", 2'b10, 8'hFE, 8'h20, 8'd4, 8'h00);

        do_req("st_40", 2'b01, 8'h40, 8'h00, 8'h00, 8'h5A);
        do_req("copy_ovl", 2'b10, 8'h40, 8'h41, 8'd3, 8'h00);

        do_req("rsvd_op", 2'b11, 8'h33, 8'h44, 8'd7, 8'h00);
        do_req("copy_len0", 2'b10, 8'h50, 8'h60, 8'd0, 8'h00);

        // COPY of five bytes interrupted by reset in cycle 7.
        w = 0;
        while (!req_ready && w < 100) begin @(negedge clk); w++; end
        req_valid = 1'b1; req_op = 2'b10; req_addr = 8'h80; req_dst = 8'h90; req_len = 8'd5;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wr_cnt = 0; rv_cnt = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (MemWrite) wr_cnt++;
            if (resp_valid) rv_cnt++;
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.strobes", {MemRead, MemWrite, resp_valid, busy, req_ready}, 5'b00000);
        chk("midrst.addr_data", {address, data_out}, 16'h0000);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (resp_valid) rv_cnt++;
        end
        rst = 1'b0;
        #1;
        chk("midrst.ready", req_ready, 1);
        chk("midrst.busy", busy, 0);
        chk("midrst.writes", wr_cnt, 2);
        chk("midrst.no_resp", rv_cnt, 0);
        for (int i = 0; i < 2; i++) ref_mem[8'h90 + 8'(i)] = ref_mem[8'h80 + 8'(i)];
        mem_cmp("midrst");
        do_req("load_after_rst", 2'b00, 8'h91, 8'h00, 8'h00, 8'h00);

        for (int k = 0; k < 30; k++)
            do_req("rand", 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                   8'($urandom_range(0, 10)), 8'($urandom));

        do_req("copy_255", 2'b10, 8'h00, 8'h01, 8'd255, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
